bypass_reg_port_arbiter: RTL and testbench
==========================================

Name: bypass_reg_port_arbiter

Overview:
- Shares the single BRAM-style port of the bypass control/status register file (64 x 512-bit entries, indexed by addr[11:6]) among N_REQ requesters, e.g. host AXI-lite bridge, TCP offload engine and DMA scheduler.
- Grants one access at a time, round-robin, and sequences the fixed slave timing: single-cycle enable pulse, then write recovery or read latency.
- Returns read data and completion to the granted requester.
- Write-protects the status half of the register file (entries 32..63).

Parameters:
N_REQ, 4, number of requesters (2..8)
RD_LAT, 2, cycles from enable-pulse cycle to slave read data valid on bram_rddata_a
WR_LAT, 1, recovery cycles after a write enable pulse before the slave accepts a new command

Ports:
user_clk  in  1  clock
user_rst  in  1  synchronous active-high reset
req_valid  in  N_REQ  per-requester command valid
req_ready  out  N_REQ  one-hot accept pulse; command consumed on req_valid&req_ready
req_we  in  N_REQ  1 = write, 0 = read
req_addr  in  N_REQ x 16  byte address; entry index = addr[11:6]
req_wrdata  in  N_REQ x 512  write data
rsp_valid  out  N_REQ  one-hot, one-cycle completion pulse to the owner
rsp_rddata  out  512  read data, valid with rsp_valid (shared bus)
rsp_err  out  1  valid with rsp_valid; 1 = write to status region dropped
bram_en_a  out  1  slave enable
bram_we_a  out  1  slave write enable
bram_addr_a  out  16  slave address
bram_wrdata_a  out  512  slave write data
bram_rddata_a  in  512  slave read data

Behaviour:
- Reset: all outputs are 0, FSM is in IDLE, and the round-robin pointer last = N_REQ-1, so requester 0 wins first.
- A reset asserted mid-transaction aborts it, with no rsp_valid. The slave is reset by the same reset.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid, pick the first set bit scanning from last+1, wrapping modulo N_REQ.
  - Assert req_ready for that requester only, in this cycle (combinational from req_valid and state).
  - Latch we/addr/wrdata/owner and set last = owner.
  - Next state: ISSUE, or RESP with err=1 if the command is a write with addr[11] = 1.
  - If no req_valid, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - Drive bram_en_a = 1, bram_we_a = latched we, addr and wrdata from the latch.
  - Load wait counter with RD_LAT for reads, WR_LAT for writes.
  - Next state: WAIT.
- Outside ISSUE, bram_en_a = bram_we_a = 0. bram_addr_a and bram_wrdata_a hold the latched values.
- WAIT: decrement the counter each cycle.
  - On the cycle the counter is 1, a read registers bram_rddata_a into rsp_rddata.
  - Then go to RESP.
- RESP (1 cycle):
  - rsp_valid[owner] = 1.
  - rsp_err = err; err is 0 for reads and accepted writes.
  - Then go to IDLE.
- Latency for an accepted read with RD_LAT = 2: accept at cycle t, enable at t+1, data captured at the end of t+3, rsp_valid at t+4. Throughput is one read per 5 cycles.
- Latency for a write with WR_LAT = 1: rsp_valid at t+3. The next accept is no earlier than t+4.
- A protected write (rejected status-region write) generates no bram_en_a. rsp_valid is at t+1 with rsp_err = 1.
- Read addresses are never rejected. Bits [15:12] and [5:0] are passed through unchanged.
- req_ready is asserted only in IDLE. Requesters must hold their command stable while req_valid is high and not accepted.
- rsp_rddata holds its last captured value. It is undefined-by-contract except during a read rsp_valid.
- Simultaneous requests are resolved strictly round-robin. No requester is starved for longer than N_REQ-1 grants.
- req_valid deasserted before acceptance is legal; the requester is simply skipped.

Test Plan:
1. Single read: after reset, write entry 3 with 512'hA5.. via requester 0. Then read addr 16'h00C0 via requester 1. Required: bram_en_a pulses once with we=0, rsp_valid[1] four cycles after accept, rsp_rddata = 512'hA5..
2. Round-robin: all 4 req_valid held continuously with reads. Required: accepts in order 0,1,2,3,0,…, and each req_ready is one-hot, 5 cycles apart.
3. Write protect: requester 2 writes addr 16'h0800 (entry 32). Required: no bram_en_a, rsp_valid[2] with rsp_err = 1 one cycle after accept, and status entry unchanged on readback.
4. Write spacing: back-to-back writes from requester 0 to entries 0 and 1. Required: bram_en_a pulses at least 3 cycles apart, and both values read back correctly.
5. Reset mid-read: assert user_rst during WAIT. Required: no rsp_valid, all outputs 0, and the next grant goes to requester 0.
6. Starvation: requester 3 continuously valid while 0..2 toggle randomly for 1000 cycles. Required: requester 3 is granted at least once every 4 grants.

Source files
------------

// File: rtl/bypass_reg_port_arbiter.sv
// bypass_reg_port_arbiter: round-robin sharing of the single BRAM port of the
// bypass control/status register file (64 x 512b, entry = addr[11:6]).
// Entries 32..63 (addr[11] = 1) are status and are write-protected.
module bypass_reg_port_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned WR_LAT = 1
) (
  input  logic                        user_clk,
  input  logic                        user_rst,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ-1:0]            req_we,
  input  logic [N_REQ-1:0][15:0]      req_addr,
  input  logic [N_REQ-1:0][511:0]     req_wrdata,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [511:0]                rsp_rddata,
  output logic                        rsp_err,
  output logic                        bram_en_a,
  output logic                        bram_we_a,
  output logic [15:0]                 bram_addr_a,
  output logic [511:0]                bram_wrdata_a,
  input  logic [511:0]                bram_rddata_a
);

  localparam int unsigned IDXW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned MAXLAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int unsigned CNTW   = (MAXLAT > 1) ? $clog2(MAXLAT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            r_state;
  logic [IDXW-1:0]   r_last;
  logic [IDXW-1:0]   r_owner;
  logic              r_we;
  logic [CNTW-1:0]   r_cnt;

  logic              w_found;
  logic [IDXW-1:0]   w_gnt;
  logic              w_take;
  logic              w_prot;
  logic [N_REQ-1:0]  w_gnt_oh;
  logic [N_REQ-1:0]  w_owner_oh;

  // Round-robin pick: lowest valid index above last, else lowest valid overall
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && req_valid[i] && (i > int'(r_last))) begin
        w_found = 1'b1;
        w_gnt   = IDXW'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && req_valid[i]) begin
        w_found = 1'b1;
        w_gnt   = IDXW'(i);
      end
    end
  end

  assign w_take     = (r_state == S_IDLE) && w_found && !user_rst;
  assign w_prot     = req_we[w_gnt] && req_addr[w_gnt][11];
  assign w_gnt_oh   = N_REQ'(1) << w_gnt;
  assign w_owner_oh = N_REQ'(1) << r_owner;
  assign req_ready  = w_take ? w_gnt_oh : '0;

  // Transaction sequencer: accept, enable pulse, latency wait, completion pulse
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      r_state       <= S_IDLE;
      r_last        <= IDXW'(N_REQ - 1);
      r_owner       <= '0;
      r_we          <= 1'b0;
      r_cnt         <= '0;
      rsp_valid     <= '0;
      rsp_rddata    <= '0;
      rsp_err       <= 1'b0;
      bram_en_a     <= 1'b0;
      bram_we_a     <= 1'b0;
      bram_addr_a   <= '0;
      bram_wrdata_a <= '0;
    end else begin
      bram_en_a <= 1'b0;
      bram_we_a <= 1'b0;
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_owner       <= w_gnt;
            r_last        <= w_gnt;
            r_we          <= req_we[w_gnt];
            bram_addr_a   <= req_addr[w_gnt];
            bram_wrdata_a <= req_wrdata[w_gnt];
            if (w_prot) begin
              // Status-region write: drop it, complete immediately with error
              rsp_valid <= w_gnt_oh;
              rsp_err   <= 1'b1;
              r_state   <= S_RESP;
            end else begin
              bram_en_a <= 1'b1;
              bram_we_a <= req_we[w_gnt];
              r_state   <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_cnt   <= r_we ? CNTW'(WR_LAT) : CNTW'(RD_LAT);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == CNTW'(1)) begin
            if (!r_we) begin
              rsp_rddata <= bram_rddata_a;
            end
            rsp_valid <= w_owner_oh;
            r_state   <= S_RESP;
          end else begin
            r_cnt <= r_cnt - CNTW'(1);
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bypass_reg_port_arbiter.sv
// Bench for bypass_reg_port_arbiter: directed vector table, reset/corner
// sequences and a randomized round-robin phase against a transaction model.
module tb_bypass_reg_port_arbiter;

  logic              user_clk = 1'b0;
  logic              user_rst;
  logic [3:0]        req_valid;
  logic [3:0]        req_ready;
  logic [3:0]        req_we;
  logic [3:0][15:0]  req_addr;
  logic [3:0][511:0] req_wrdata;
  logic [3:0]        rsp_valid;
  logic [511:0]      rsp_rddata;
  logic              rsp_err;
  logic              bram_en_a;
  logic              bram_we_a;
  logic [15:0]       bram_addr_a;
  logic [511:0]      bram_wrdata_a;
  logic [511:0]      bram_rddata_a;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_en = -100;

  logic [511:0] shadow [64];

  bypass_reg_port_arbiter #(.N_REQ(4), .RD_LAT(2), .WR_LAT(1)) dut (
    .user_clk      (user_clk),
    .user_rst      (user_rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wrdata    (req_wrdata),
    .rsp_valid     (rsp_valid),
    .rsp_rddata    (rsp_rddata),
    .rsp_err       (rsp_err),
    .bram_en_a     (bram_en_a),
    .bram_we_a     (bram_we_a),
    .bram_addr_a   (bram_addr_a),
    .bram_wrdata_a (bram_wrdata_a),
    .bram_rddata_a (bram_rddata_a)
  );

  always #5 user_clk = ~user_clk;

  always @(posedge user_clk) cyc <= cyc + 1;

  function automatic logic [511:0] pat(input int e);
    return {16{32'hC0DE_0000 | 32'(e)}};
  endfunction

  function automatic int oh(input int i);
    return 1 << i;
  endfunction

  // Slave model: 64 x 512 register file, read data two cycles after enable
  logic [511:0] mem [64];
  logic [511:0] s1;
  always @(posedge user_clk) begin
    if (user_rst) begin
      s1            <= '0;
      bram_rddata_a <= '0;
      for (int e = 0; e < 64; e++) mem[e] <= pat(e);
    end else begin
      if (bram_en_a && bram_we_a) mem[bram_addr_a[11:6]] <= bram_wrdata_a;
      if (bram_en_a && !bram_we_a) s1 <= mem[bram_addr_a[11:6]];
      bram_rddata_a <= s1;
    end
  end

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chkw(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic check_zero(input string nm);
    chki({nm, "_req_ready"}, int'(req_ready), 0);
    chki({nm, "_rsp_valid"}, int'(rsp_valid), 0);
    chki({nm, "_rsp_err"},   int'(rsp_err), 0);
    chki({nm, "_en"},        int'(bram_en_a), 0);
    chki({nm, "_we"},        int'(bram_we_a), 0);
    chki({nm, "_addr"},      int'(bram_addr_a), 0);
    chkw({nm, "_rddata"},    rsp_rddata, '0);
    chkw({nm, "_wrdata"},    bram_wrdata_a, '0);
  endtask

  task automatic do_reset(input string nm);
    @(negedge user_clk);
    user_rst  = 1'b1;
    req_valid = 4'hF;
    repeat (2) @(negedge user_clk);
    #1;
    check_zero(nm);
    req_valid = '0;
    user_rst  = 1'b0;
    for (int e = 0; e < 64; e++) shadow[e] = pat(e);
  endtask

  // Wait (bounded) for any req_ready; caller is at negedge+1
  task automatic wait_ready(output bit got);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (req_ready != 0) got = 1'b1;
      else begin
        @(negedge user_clk);
        #1;
      end
    end
  endtask

  typedef struct {
    int           req;
    bit           we;
    logic [15:0]  addr;
    logic [511:0] wd;
    bit           err;
    int           lat;
    logic [511:0] rd;
  } vec_t;

  vec_t vecs [10];

  task automatic do_txn(input vec_t v);
    bit got;
    int lat, n_en, n_rsp;
    @(negedge user_clk);
    req_valid          = 4'(oh(v.req));
    req_we[v.req]      = v.we;
    req_addr[v.req]    = v.addr;
    req_wrdata[v.req]  = v.wd;
    #1;
    wait_ready(got);
    chki("vec_grant", int'(req_ready), oh(v.req));
    lat = 0; n_en = 0; n_rsp = 0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge user_clk);
      if (k == 1) req_valid = '0;
      if (bram_en_a) begin
        n_en++;
        chki("vec_en_cycle", k, 1);
        chki("vec_en_we", int'(bram_we_a), int'(v.we));
        chki("vec_en_addr", int'(bram_addr_a), int'(v.addr));
        if (v.we) chkw("vec_en_wrdata", bram_wrdata_a, v.wd);
        chki("vec_en_spacing_ge3", int'((cyc - last_en) >= 3), 1);
        last_en = cyc;
      end
      if (rsp_valid != 0) begin
        n_rsp++;
        if (n_rsp == 1) begin
          lat = k;
          chki("vec_rsp_owner", int'(rsp_valid), oh(v.req));
          chki("vec_rsp_err", int'(rsp_err), int'(v.err));
          if (!v.we) chkw("vec_rddata", rsp_rddata, v.rd);
        end
      end
    end
    chki("vec_en_count", n_en, v.err ? 0 : 1);
    chki("vec_rsp_count", n_rsp, 1);
    chki("vec_latency", lat, v.lat);
  endtask

  // Randomized phase; mode 0: all four reading continuously,
  // mode 1: requester 3 always valid, 0..2 toggle randomly.
  task automatic run_rand(input int ncyc, input int mode);
    int m_last = 3, m_idle = 0, p_en = -1, p_rsp = -1, p_owner = 0;
    int starve = 0, prev_owner = -1, prev_c = 0, own = 0, acc = -1;
    int exp_rv, exp_rdy;
    bit p_we = 1'b0, p_err = 1'b0;
    logic [15:0]  p_addr = '0;
    logic [511:0] p_wd = '0, p_rd = '0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge user_clk);
      exp_rv = (c == p_rsp) ? oh(p_owner) : 0;
      chki("rr_rsp_valid", int'(rsp_valid), exp_rv);
      if (exp_rv != 0) begin
        chki("rr_rsp_err", int'(rsp_err), int'(p_err));
        if (!p_we) chkw("rr_rddata", rsp_rddata, p_rd);
      end
      chki("rr_en", int'(bram_en_a), (c == p_en) ? 1 : 0);
      if (c == p_en) begin
        chki("rr_en_we", int'(bram_we_a), int'(p_we));
        chki("rr_en_addr", int'(bram_addr_a), int'(p_addr));
        if (p_we) chkw("rr_en_wrdata", bram_wrdata_a, p_wd);
      end
      if (acc >= 0) req_valid[acc] = 1'b0;
      acc = -1;
      for (int i = 0; i < 4; i++) begin
        if (!req_valid[i]) begin
          if (mode == 0 || i == 3 || $urandom_range(0, 2) == 0) begin
            req_valid[i]  = 1'b1;
            req_we[i]     = (mode == 0) ? 1'b0 : ($urandom_range(0, 2) == 0);
            req_addr[i]   = 16'($urandom);
            req_wrdata[i] = {16{$urandom}};
          end
        end else if (mode == 1 && i != 3 && $urandom_range(0, 7) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      #1;
      exp_rdy = 0;
      if (c >= m_idle) begin
        for (int k = 1; k <= 4; k++) begin
          if (exp_rdy == 0 && req_valid[(m_last + k) % 4]) begin
            own     = (m_last + k) % 4;
            exp_rdy = oh(own);
          end
        end
      end
      chki("rr_req_ready", int'(req_ready), exp_rdy);
      if (exp_rdy != 0) begin
        acc     = own;
        p_owner = own;
        p_we    = req_we[own];
        p_addr  = req_addr[own];
        p_wd    = req_wrdata[own];
        p_err   = p_we && p_addr[11];
        if (p_err) begin
          p_en   = -1;
          p_rsp  = c + 1;
          m_idle = c + 2;
        end else begin
          p_en   = c + 1;
          p_rsp  = c + (p_we ? 3 : 4);
          m_idle = c + (p_we ? 4 : 5);
          if (p_we) shadow[p_addr[11:6]] = p_wd;
          else      p_rd = shadow[p_addr[11:6]];
        end
        m_last = own;
        if (mode == 1) begin
          if (own == 3) starve = 0;
          else begin
            starve++;
            chki("starve_r3_within_4", int'(starve <= 3), 1);
          end
        end else begin
          if (prev_owner >= 0) begin
            chki("rr_order", own, (prev_owner + 1) % 4);
            chki("rr_spacing", c - prev_c, 5);
          end
          prev_owner = own;
          prev_c     = c;
        end
      end
    end
    @(negedge user_clk);
    req_valid = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    user_rst   = 1'b1;
    req_valid  = '0;
    req_we     = '0;
    req_addr   = '0;
    req_wrdata = '0;

    vecs[0] = '{0, 1'b1, 16'h00C0, {64{8'hA5}}, 1'b0, 3, '0};
    vecs[1] = '{1, 1'b0, 16'h00C0, '0,          1'b0, 4, {64{8'hA5}}};
    vecs[2] = '{2, 1'b1, 16'h0800, {64{8'hFF}}, 1'b1, 1, '0};
    vecs[3] = '{2, 1'b0, 16'h0800, '0,          1'b0, 4, pat(32)};
    vecs[4] = '{0, 1'b1, 16'h0000, {64{8'h11}}, 1'b0, 3, '0};
    vecs[5] = '{0, 1'b1, 16'h0040, {64{8'h22}}, 1'b0, 3, '0};
    vecs[6] = '{3, 1'b0, 16'h0000, '0,          1'b0, 4, {64{8'h11}}};
    vecs[7] = '{3, 1'b0, 16'h0040, '0,          1'b0, 4, {64{8'h22}}};
    vecs[8] = '{1, 1'b0, 16'hF07F, '0,          1'b0, 4, {64{8'h22}}};
    vecs[9] = '{1, 1'b1, 16'hFFC0, {64{8'h33}}, 1'b1, 1, '0};

    do_reset("reset");
    for (int i = 0; i < 10; i++) do_txn(vecs[i]);

    // Reset during WAIT of a read: no completion, outputs cleared, requester 0 next
    do_reset("reset2");
    @(negedge user_clk);
    req_valid   = 4'b0100;
    req_we[2]   = 1'b0;
    req_addr[2] = 16'h0100;
    #1;
    wait_ready(got);
    chki("midrst_grant", int'(req_ready), 4);
    @(negedge user_clk);
    req_valid = '0;
    chki("midrst_en", int'(bram_en_a), 1);
    @(negedge user_clk);
    user_rst  = 1'b1;
    req_valid = 4'hF;
    @(negedge user_clk);
    #1;
    check_zero("midrst");
    user_rst = 1'b0;
    #1;
    chki("midrst_next_grant", int'(req_ready), 1);
    chki("midrst_no_rsp", int'(rsp_valid), 0);
    @(negedge user_clk);
    req_valid = '0;
    chki("midrst_no_rsp2", int'(rsp_valid), 0);

    do_reset("reset3");
    run_rand(60, 0);
    do_reset("reset4");
    run_rand(1000, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
